// File: rtl/wrsw_phy_fault_pkg.sv
// Shared types, constants and 8b/10b running-disparity helpers for the PHY fault injector.
// Latency: n/a (package only).
// Backpressure: n/a.
package wrsw_phy_fault_pkg;

  // Command modes; 00 doubles as the abort command.
  typedef enum logic [1:0] {
    MODE_PASS        = 2'b00,
    MODE_IDLE_ERR    = 2'b01,
    MODE_ERR_ONLY    = 2'b10,
    MODE_IDLE_SILENT = 2'b11
  } fault_mode_e;

  typedef enum logic {
    ST_PASS  = 1'b0,
    ST_FAULT = 1'b1
  } lane_state_e;

  // Idle words substituted during a fault: K28.5 in the low byte.
  localparam logic [15:0] c_idle_dat16 = 16'h00BC;
  localparam logic [1:0]  c_idle_k16   = 2'b01;
  localparam logic [7:0]  c_idle_dat8  = 8'hBC;
  localparam logic        c_idle_k8    = 1'b1;

  // Disparity-flip tables, written MSB-first: entry 0 is the leftmost bit.
  localparam logic [31:0] c_dp6 = 32'b11101000100000011000000110010111;
  localparam logic [7:0]  c_dp4 = 8'b10001001;

  // One byte of running disparity. K codes with d[1:0] != 0 are balanced
  // and leave the disparity untouched.
  function automatic logic disp_byte(input logic disp, input logic [7:0] d, input logic k);
    logic flip;
    flip = k ^ c_dp6[5'd31 - d[4:0]] ^ c_dp4[3'd7 - d[7:5]];
    if (k && (d[1:0] != 2'b00)) begin
      return disp;
    end
    return disp ^ flip;
  endfunction

  function automatic logic disp8(input logic disp, input logic [7:0] d, input logic k);
    return disp_byte(disp, d, k);
  endfunction

  // High byte goes on the wire first, so it is applied first.
  function automatic logic disp16(input logic disp, input logic [15:0] d, input logic [1:0] k);
    return disp_byte(disp_byte(disp, d[15:8], k[1]), d[7:0], k[0]);
  endfunction

endpackage

// File: rtl/wrsw_phy_fault_lane.sv
// One PHY lane: registered TX path with idle/error substitution, disparity tracking, error counter.
// Latency: 1 cycle data/K in every mode; command takes effect on the word registered next cycle.
// Backpressure: none; a new command overrides any fault in progress.
//
// Ports: clk/rst_n; tx_data/tx_k endpoint word; cmd_hit/cmd_mode/cmd_len decoded command;
//        out_data/out_k PHY word; disparity/enc_err feedback; active fault flag; err_cnt.
module wrsw_phy_fault_lane
  import wrsw_phy_fault_pkg::*;
#(
  parameter int  g_pcs_16bit = 1,
  parameter int  g_cnt_width = 16,
  localparam int W  = (g_pcs_16bit != 0) ? 16 : 8,
  localparam int KW = (g_pcs_16bit != 0) ? 2 : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W-1:0]           tx_data,
  input  logic [KW-1:0]          tx_k,
  input  logic                   cmd_hit,
  input  fault_mode_e            cmd_mode,
  input  logic [g_cnt_width-1:0] cmd_len,
  output logic [W-1:0]           out_data,
  output logic [KW-1:0]          out_k,
  output logic                   disparity,
  output logic                   enc_err,
  output logic                   active,
  output logic [g_cnt_width-1:0] err_cnt
);

  localparam logic [W-1:0]  c_idle_dat = (W == 16) ? W'(c_idle_dat16) : W'(c_idle_dat8);
  localparam logic [KW-1:0] c_idle_k   = (KW == 2) ? KW'(c_idle_k16)  : KW'(c_idle_k8);

  lane_state_e            state;
  fault_mode_e            mode;
  // Remaining faulted words; zero while in FAULT means "until aborted".
  logic [g_cnt_width-1:0] remain;

  logic          sub_idle;
  logic          sub_err;
  logic [W-1:0]  nxt_data;
  logic [KW-1:0] nxt_k;
  logic          nxt_disp;

  always_comb begin
    sub_idle = 1'b0;
    sub_err  = 1'b0;
    if (state == ST_FAULT) begin
      sub_idle = (mode == MODE_IDLE_ERR) || (mode == MODE_IDLE_SILENT);
      sub_err  = (mode == MODE_IDLE_ERR) || (mode == MODE_ERR_ONLY);
    end
    nxt_data = sub_idle ? c_idle_dat : tx_data;
    nxt_k    = sub_idle ? c_idle_k   : tx_k;
  end

  // Disparity follows the word actually leaving the block, substitutions included.
  if (W == 16) begin : g_disp16
    assign nxt_disp = disp16(disparity, nxt_data, nxt_k);
  end else begin : g_disp8
    assign nxt_disp = disp8(disparity, nxt_data, nxt_k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_k     <= '0;
      enc_err   <= 1'b0;
      disparity <= 1'b0;
      err_cnt   <= '0;
    end else begin
      out_data  <= nxt_data;
      out_k     <= nxt_k;
      enc_err   <= sub_err;
      disparity <= nxt_disp;
      // Counts cycles where the error flag is presented, saturating.
      if (enc_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + g_cnt_width'(1);
      end
    end
  end

  // Lane FSM; active is kept in step with state as a registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_PASS;
      mode   <= MODE_PASS;
      remain <= '0;
      active <= 1'b0;
    end else if (cmd_hit) begin
      if (cmd_mode == MODE_PASS) begin
        state  <= ST_PASS;
        active <= 1'b0;
      end else begin
        state  <= ST_FAULT;
        active <= 1'b1;
        mode   <= cmd_mode;
        remain <= cmd_len;
      end
    end else if ((state == ST_FAULT) && (remain != '0)) begin
      if (remain == g_cnt_width'(1)) begin
        state  <= ST_PASS;
        active <= 1'b0;
        remain <= '0;
      end else begin
        remain <= remain - g_cnt_width'(1);
      end
    end
  end

endmodule

// File: rtl/wrsw_phy_fault_inj.sv
// PHY-side fault injector for switch endpoints: per-lane idle/error substitution under command control.
// Latency: 1 cycle on the data/K path; commands act on the word registered the cycle after acceptance.
// Backpressure: none; cmd_ready_o is high whenever out of reset, commands never stall.
//
// Ports: clk_sys_i/rst_n_i; tx_data_i/tx_k_i endpoint lanes in; tx_data_o/tx_k_o toward PHY;
//        tx_disparity_o/tx_enc_err_o fed back to endpoint; cmd_* command bus; active_o, err_cnt_o status.
module wrsw_phy_fault_inj
  import wrsw_phy_fault_pkg::*;
#(
  parameter int  g_num_ports = 6,
  parameter int  g_pcs_16bit = 1,
  parameter int  g_cnt_width = 16,
  localparam int W  = (g_pcs_16bit != 0) ? 16 : 8,
  localparam int KW = (g_pcs_16bit != 0) ? 2 : 1,
  localparam int PW = (g_num_ports > 1) ? $clog2(g_num_ports) : 1
) (
  input  logic                               clk_sys_i,
  input  logic                               rst_n_i,
  input  logic [g_num_ports*W-1:0]           tx_data_i,
  input  logic [g_num_ports*KW-1:0]          tx_k_i,
  output logic [g_num_ports*W-1:0]           tx_data_o,
  output logic [g_num_ports*KW-1:0]          tx_k_o,
  output logic [g_num_ports-1:0]             tx_disparity_o,
  output logic [g_num_ports-1:0]             tx_enc_err_o,
  input  logic                               cmd_valid_i,
  input  logic [PW-1:0]                      cmd_port_i,
  input  logic [1:0]                         cmd_mode_i,
  input  logic [g_cnt_width-1:0]             cmd_len_i,
  output logic                               cmd_ready_o,
  output logic [g_num_ports-1:0]             active_o,
  output logic [g_num_ports*g_cnt_width-1:0] err_cnt_o
);

  fault_mode_e cmd_mode;

  assign cmd_ready_o = rst_n_i;
  assign cmd_mode    = fault_mode_e'(cmd_mode_i);

  // A port number beyond the last lane matches no lane and is dropped silently.
  for (genvar j = 0; j < g_num_ports; j++) begin : g_lane
    logic hit;
    assign hit = cmd_valid_i & cmd_ready_o & (cmd_port_i == PW'(j));

    wrsw_phy_fault_lane #(
      .g_pcs_16bit (g_pcs_16bit),
      .g_cnt_width (g_cnt_width)
    ) u_lane (
      .clk       (clk_sys_i),
      .rst_n     (rst_n_i),
      .tx_data   (tx_data_i[W*j +: W]),
      .tx_k      (tx_k_i[KW*j +: KW]),
      .cmd_hit   (hit),
      .cmd_mode  (cmd_mode),
      .cmd_len   (cmd_len_i),
      .out_data  (tx_data_o[W*j +: W]),
      .out_k     (tx_k_o[KW*j +: KW]),
      .disparity (tx_disparity_o[j]),
      .enc_err   (tx_enc_err_o[j]),
      .active    (active_o[j]),
      .err_cnt   (err_cnt_o[g_cnt_width*j +: g_cnt_width])
    );
  end

endmodule

// File: tb/tb_wrsw_phy_fault_inj.sv
// Bench: two injector instances (6x16-bit, 2x8-bit with narrow counters) checked by a scoreboard.
// A window-based reference model predicts every output word; a monitor compares after each edge.
module tb_wrsw_phy_fault_inj;

  localparam int NA = 6, NB = 2, NL = NA + NB;
  localparam int CWA = 16, CWB = 4;
  localparam longint MAXL = 64'h7fff_ffff_ffff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NA*16-1:0]  tx_data_a, txo_data_a;
  logic [NA*2-1:0]   tx_k_a, txo_k_a;
  logic [NA-1:0]     disp_a, err_a, act_a;
  logic [NA*CWA-1:0] cnt_a;
  logic              cv_a, rdy_a;
  logic [2:0]        cp_a;
  logic [1:0]        cm_a;
  logic [CWA-1:0]    cl_a;

  logic [NB*8-1:0]   tx_data_b, txo_data_b;
  logic [NB-1:0]     tx_k_b, txo_k_b;
  logic [NB-1:0]     disp_b, err_b, act_b;
  logic [NB*CWB-1:0] cnt_b;
  logic              cv_b, rdy_b;
  logic [0:0]        cp_b;
  logic [1:0]        cm_b;
  logic [CWB-1:0]    cl_b;

  wrsw_phy_fault_inj #(.g_num_ports(NA), .g_pcs_16bit(1), .g_cnt_width(CWA)) dut_a (
    .clk_sys_i(clk), .rst_n_i(rst_n), .tx_data_i(tx_data_a), .tx_k_i(tx_k_a),
    .tx_data_o(txo_data_a), .tx_k_o(txo_k_a), .tx_disparity_o(disp_a), .tx_enc_err_o(err_a),
    .cmd_valid_i(cv_a), .cmd_port_i(cp_a), .cmd_mode_i(cm_a), .cmd_len_i(cl_a),
    .cmd_ready_o(rdy_a), .active_o(act_a), .err_cnt_o(cnt_a));

  wrsw_phy_fault_inj #(.g_num_ports(NB), .g_pcs_16bit(0), .g_cnt_width(CWB)) dut_b (
    .clk_sys_i(clk), .rst_n_i(rst_n), .tx_data_i(tx_data_b), .tx_k_i(tx_k_b),
    .tx_data_o(txo_data_b), .tx_k_o(txo_k_b), .tx_disparity_o(disp_b), .tx_enc_err_o(err_b),
    .cmd_valid_i(cv_b), .cmd_port_i(cp_b), .cmd_mode_i(cm_b), .cmd_len_i(cl_b),
    .cmd_ready_o(rdy_b), .active_o(act_b), .err_cnt_o(cnt_b));

  typedef struct packed {
    logic [NL-1:0][15:0] dat;
    logic [NL-1:0][1:0]  k;
    logic [NL-1:0]       disp;
    logic [NL-1:0]       err;
    logic [NL-1:0]       act;
    logic [NL-1:0][15:0] cnt;
    logic                rdy;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  bit   force_1234 = 1'b0;

  // Reference model: each lane holds a fault window [st, en] of output-edge indices.
  longint ncyc = 0;
  longint st[NL], en[NL];
  int     md[NL], mcnt[NL];
  logic   mdisp[NL], merr[NL];

  task automatic chk(input string nm, input int lane, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s lane=%0d got=%0h want=%0h t=%0t", nm, lane, got, want, $time);
    end
  endtask

  function automatic logic db(input logic d0, input logic [7:0] b, input logic k);
    string s6, s4;
    logic  f;
    s6 = "11101000100000011000000110010111";
    s4 = "10001001";
    if (k && (b[1:0] != 2'b00)) return d0;
    f = k ^ (s6[int'(b[4:0])] == 8'h31) ^ (s4[int'(b[7:5])] == 8'h31);
    return d0 ^ f;
  endfunction

  // Drives one cycle of stimulus at the falling edge and queues the prediction for the next rising edge.
  task automatic tick(input bit r, input bit va, input int pa, input int ma, input int la,
                      input bit vb, input int pb, input int mb, input int lb);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    cv_a = va; cp_a = 3'(pa); cm_a = 2'(ma); cl_a = CWA'(la);
    cv_b = vb; cp_b = 1'(pb); cm_b = 2'(mb); cl_b = CWB'(lb);
    for (int g = 0; g < NA; g++) begin
      tx_data_a[16*g +: 16] = 16'($urandom);
      tx_k_a[2*g +: 2]      = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
    end
    for (int g = 0; g < NB; g++) begin
      tx_data_b[8*g +: 8] = 8'($urandom);
      tx_k_b[g]           = ($urandom_range(0, 3) == 0);
    end
    if (force_1234) begin
      tx_data_a[15:0] = 16'h1234;
      tx_k_a[1:0]     = 2'b00;
    end
    e = '0;
    if (!r) begin
      for (int g = 0; g < NL; g++) begin
        st[g] = 1; en[g] = 0; md[g] = 0; mcnt[g] = 0; mdisp[g] = 1'b0; merr[g] = 1'b0;
      end
    end else begin
      e.rdy = 1'b1;
      for (int g = 0; g < NL; g++) begin
        bit          is16, f, hit;
        int          li, maxc, mode, len;
        logic [15:0] w;
        logic [1:0]  kk;
        is16 = (g < NA);
        li   = is16 ? g : g - NA;
        w    = is16 ? tx_data_a[16*li +: 16] : {8'h00, tx_data_b[8*li +: 8]};
        kk   = is16 ? tx_k_a[2*li +: 2] : {1'b0, tx_k_b[li]};
        f    = (st[g] <= ncyc) && (ncyc <= en[g]);
        if (f && (md[g] == 1 || md[g] == 3)) begin
          w  = 16'h00BC;
          kk = 2'b01;
        end
        maxc = is16 ? 65535 : 15;
        if (merr[g] && mcnt[g] < maxc) mcnt[g]++;
        merr[g] = f && (md[g] == 1 || md[g] == 2);
        if (is16) mdisp[g] = db(db(mdisp[g], w[15:8], kk[1]), w[7:0], kk[0]);
        else      mdisp[g] = db(mdisp[g], w[7:0], kk[0]);
        hit  = is16 ? (va && pa == li) : (vb && pb == li);
        mode = is16 ? ma : mb;
        len  = is16 ? la : lb;
        if (hit) begin
          if (mode == 0) en[g] = ncyc;
          else begin
            st[g] = ncyc + 1;
            en[g] = (len == 0) ? MAXL : ncyc + len;
            md[g] = mode;
          end
        end
        e.dat[g]  = w;
        e.k[g]    = kk;
        e.disp[g] = mdisp[g];
        e.err[g]  = merr[g];
        e.act[g]  = (st[g] <= ncyc + 1) && (ncyc + 1 <= en[g]);
        e.cnt[g]  = 16'(mcnt[g]);
      end
    end
    ncyc++;
    expq.push_back(e);
  endtask

  task automatic tick_idle(input bit r);
    tick(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one prediction per rising edge and compares every lane.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ready_a", -1, 16'(rdy_a), 16'(e.rdy));
        chk("ready_b", -1, 16'(rdy_b), 16'(e.rdy));
        for (int g = 0; g < NL; g++) begin
          if (g < NA) begin
            chk("data", g, txo_data_a[16*g +: 16], e.dat[g]);
            chk("k", g, 16'(txo_k_a[2*g +: 2]), 16'(e.k[g]));
            chk("disp", g, 16'(disp_a[g]), 16'(e.disp[g]));
            chk("enc_err", g, 16'(err_a[g]), 16'(e.err[g]));
            chk("active", g, 16'(act_a[g]), 16'(e.act[g]));
            chk("err_cnt", g, cnt_a[CWA*g +: CWA], e.cnt[g]);
          end else begin
            chk("data", g, 16'(txo_data_b[8*(g-NA) +: 8]), e.dat[g]);
            chk("k", g, 16'(txo_k_b[g-NA]), 16'(e.k[g]));
            chk("disp", g, 16'(disp_b[g-NA]), 16'(e.disp[g]));
            chk("enc_err", g, 16'(err_b[g-NA]), 16'(e.err[g]));
            chk("active", g, 16'(act_b[g-NA]), 16'(e.act[g]));
            chk("err_cnt", g, 16'(cnt_b[CWB*(g-NA) +: CWB]), e.cnt[g]);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cv_a = 0; cp_a = '0; cm_a = '0; cl_a = '0; tx_data_a = '0; tx_k_a = '0;
    cv_b = 0; cp_b = '0; cm_b = '0; cl_b = '0; tx_data_b = '0; tx_k_b = '0;
    repeat (3) tick_idle(0);

    // Passthrough right after reset.
    force_1234 = 1'b1;
    tick_idle(1);
    force_1234 = 1'b0;
    @(posedge clk); #1;
    chk("pass_data", 0, txo_data_a[15:0], 16'h1234);
    chk("pass_err", 0, 16'(err_a[0]), 16'h0);
    chk("pass_act", 0, 16'(act_a[0]), 16'h0);

    // Timed IDLE_ERR fault on lane 2.
    tick(1, 1, 2, 1, 5, 0, 0, 0, 0);
    repeat (8) tick_idle(1);
    chk("cnt_after5", 2, cnt_a[CWA*2 +: CWA], 16'd5);
    chk("act_after5", 2, 16'(act_a[2]), 16'h0);

    // Indefinite IDLE_SILENT on lane 1, aborted after 100 cycles.
    tick(1, 1, 1, 3, 0, 0, 0, 0, 0);
    repeat (100) tick_idle(1);
    chk("silent_data", 1, txo_data_a[31:16], 16'h00BC);
    chk("silent_err", 1, 16'(err_a[1]), 16'h0);
    tick(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("act_before_abort", 1, 16'(act_a[1]), 16'h1);
    tick_idle(1);
    chk("act_after_abort", 1, 16'(act_a[1]), 16'h0);

    // Out-of-range port is ignored.
    tick(1, 1, 7, 1, 3, 0, 0, 0, 0);
    repeat (3) tick_idle(1);
    chk("bad_port_act", -1, 16'(act_a), 16'h0);
    chk("bad_port_err", -1, 16'(err_a), 16'h0);

    // Reset pulse in the middle of an indefinite fault.
    tick(1, 1, 3, 1, 0, 0, 0, 0, 0);
    repeat (4) tick_idle(1);
    chk("pre_rst_act", 3, 16'(act_a[3]), 16'h1);
    tick_idle(0);
    #1;
    chk("rst_act", -1, 16'(act_a), 16'h0);
    chk("rst_err", -1, 16'(err_a), 16'h0);
    chk("rst_data", 3, txo_data_a[63:48], 16'h0);
    chk("rst_cnt", 2, cnt_a[CWA*2 +: CWA], 16'h0);
    chk("rst_rdy", -1, 16'(rdy_a), 16'h0);
    tick_idle(0);
    repeat (3) tick_idle(1);
    chk("post_rst_act", 3, 16'(act_a[3]), 16'h0);
    chk("post_rst_err", 3, 16'(err_a[3]), 16'h0);

    // Counter saturation on the narrow 8-bit instance.
    tick(1, 0, 0, 0, 0, 1, 0, 2, 0);
    repeat (25) tick_idle(1);
    chk("sat_cnt", 6, 16'(cnt_b[CWB-1:0]), 16'hF);
    chk("sat_act", 6, 16'(act_b[0]), 16'h1);
    tick(1, 0, 0, 0, 0, 1, 0, 0, 0);

    // Random commands, data and occasional reset pulses on both instances.
    for (int i = 0; i < 1500; i++) begin
      bit r, va, vb;
      r  = ($urandom_range(0, 399) != 0);
      va = ($urandom_range(0, 5) == 0);
      vb = ($urandom_range(0, 5) == 0);
      tick(r, va, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 12),
           vb, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 12));
    end

    tick_idle(1);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", -1, 16'(expq.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrsw_phy_fault_inj.md
WRSW_PHY_FAULT_INJ -- requirements
Module: wrsw_phy_fault_inj

Interface
REQ-001 SHALL have parameter g_num_ports, default 6, number of independent PHY lanes.
REQ-002 SHALL have parameter g_pcs_16bit, default 1; 1 = 16-bit lane (W=16, KW=2), 0 = 8-bit lane (W=8, KW=1).
REQ-003 SHALL have parameter g_cnt_width, default 16, width of the duration and error counters.
REQ-004 SHALL have clk_sys_i  in  1  the single clock for all logic.
REQ-005 SHALL have rst_n_i  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have tx_data_i  in  g_num_ports*W  endpoint TX data; lane j at [W*j+W-1:W*j].
REQ-007 SHALL have tx_k_i  in  g_num_ports*KW  endpoint TX K flags, packed the same way.
REQ-008 SHALL have tx_data_o  out  g_num_ports*W  data toward the PHY/switch.
REQ-009 SHALL have tx_k_o  out  g_num_ports*KW  K flags toward the PHY/switch.
REQ-010 SHALL have tx_disparity_o  out  g_num_ports  running disparity per lane, fed back to the endpoint.
REQ-011 SHALL have tx_enc_err_o  out  g_num_ports  encoding-error flag per lane, fed back to the endpoint.
REQ-012 SHALL have cmd_valid_i  in  1, cmd_port_i  in  $clog2(g_num_ports), cmd_mode_i  in  2, cmd_len_i  in  g_cnt_width; command bus.
REQ-013 SHALL have cmd_ready_o  out  1  command acceptance.
REQ-014 SHALL have active_o  out  g_num_ports  lane fault in progress.
REQ-015 SHALL have err_cnt_o  out  g_num_ports*g_cnt_width  saturating count of enc_err cycles per lane.

Function
REQ-016 Modes SHALL be: 00 PASS/abort, 01 IDLE_ERR (idle substituted, enc_err=1), 10 ERR_ONLY (data passes, enc_err=1), 11 IDLE_SILENT (idle substituted, enc_err=0).
REQ-017 Idle word SHALL be 16'h00BC with k=2'b01 for W=16, 8'hBC with k=1'b1 for W=8.
REQ-018 Data/K path SHALL be registered: one clk_sys_i cycle latency in every mode.
REQ-019 cmd_ready_o SHALL be 1 whenever reset is deasserted; a command is taken on cmd_valid_i & cmd_ready_o.
REQ-020 Commands with cmd_port_i >= g_num_ports SHALL be ignored, no state change.
REQ-021 Per-lane FSM SHALL have states PASS and FAULT; accepted non-00 command -> FAULT with counter loaded to cmd_len_i; mode 00 -> PASS next cycle.
REQ-022 Fault effect SHALL apply to the output word registered in the cycle after acceptance, for exactly cmd_len_i cycles, then the lane returns to PASS.
REQ-023 cmd_len_i = 0 SHALL mean indefinite fault until a mode-00 command.
REQ-024 A command to a lane already in FAULT SHALL override mode and reload the counter (no queueing).
REQ-025 active_o[j] SHALL be 1 exactly while lane j is in FAULT.
REQ-026 Running disparity SHALL be updated every cycle from the output word: per byte, flip if k ^ dp6[d[4:0]] ^ dp4[d[7:5]], where dp6 = 32'b11101000100000011000000110010111 and dp4 = 8'b10001001, MSB-indexed from 0; hold if k=1 and d[1:0] != 0.
REQ-027 For W=16 the high byte d[15:8] SHALL be applied first, the low byte second; both bytes SHALL be fully used.
REQ-028 err_cnt_o[j] SHALL increment on each cycle tx_enc_err_o[j]=1 and saturate at all-ones.

Reset
REQ-029 On rst_n_i low: tx_data_o=0, tx_k_o=0, tx_disparity_o=0, tx_enc_err_o=0, active_o=0, err_cnt_o=0, cmd_ready_o=0, all lanes PASS.
REQ-030 Reset asserted mid-fault SHALL abort the fault at once; after release all lanes start in PASS.

Structure
REQ-031 Package wrsw_phy_fault_pkg SHALL hold the mode enum, idle constants, dp6/dp4 tables and the 8/16-bit disparity functions.
REQ-032 Per-lane logic SHALL be sub-module wrsw_phy_fault_lane, instantiated g_num_ports times by generate; top holds command decode only.

Verification
REQ-033 Reset, PASS, lane0 in=16'h1234 k=00 -> next cycle out=16'h1234, enc_err=0, active=0.
REQ-034 Cmd port2 mode01 len=5 -> lane2 outputs 16'h00BC k=01, enc_err=1 for 5 cycles, then passthrough; err_cnt[2]=5.
REQ-035 Cmd port1 mode11 len=0, then mode00 after 100 cycles -> idle for 100 cycles, enc_err=0, active drops one cycle after abort.
REQ-036 Command with cmd_port_i=7 (g_num_ports=6) -> no output or state change.
REQ-037 Random stream on all lanes -> tx_disparity_o matches a reference model of REQ-026/027 every cycle, for W=16 and W=8.
REQ-038 Reset pulsed during mode01 len=0 -> all outputs 0 during reset, lane in PASS after release.
